// File: rtl/vga_pll_ctrl_pkg.sv
// Shared types and defaults for the VGA pixel-PLL reset/lock sequencer.
// The state encoding is visible on the debug port, so the enum values are fixed.
package vga_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int unsigned DEF_RST_HOLD_CYCLES     = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int unsigned DEF_MAX_RETRIES         = 7;
    localparam int unsigned DEF_CNT_W               = 16;
    localparam int unsigned LOST_CNT_W              = 8;

    // The PLL is held in reset while sequencing starts and while parked in FAULT.
    function automatic logic drives_pll_rst(state_e s);
        return (s == ST_PLL_RST) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/vga_pll_ctrl_sync.sv
// Generic two-flop synchroniser; both stages clear to 0 on synchronous reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_pll_ctrl.sv
// Reset/lock sequencer for the VGA pixel PLL: holds PLL reset, qualifies lock,
// releases the VGA-domain reset after sustained lock, retries, and faults out.
module vga_pll_ctrl
    import vga_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W               = DEF_CNT_W
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  restart_req,
    output logic                  pll_rst,
    output logic                  vga_rst,
    output logic                  ready,
    output logic                  fault,
    output logic [2:0]            state,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0]   HOLD_TC    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_TC  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [LOST_CNT_W-1:0]   lost_q, lost_d;
    logic                    locked_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        lost_d  = lost_q;

        // Loss is counted independently of restart_req so a coincident request still records it.
        if (state_q == ST_RUN && !locked_s && lost_q != '1) begin
            lost_d = lost_q + 1'b1;
        end

        if (restart_req) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == HOLD_TC) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_TC) begin
                        cnt_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_PLL_RST;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_TC) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt_d   = '0;
                    retry_d = '0;
                    if (!locked_s) begin
                        state_d = ST_PLL_RST;
                    end
                end
                ST_FAULT: begin
                    cnt_d = '0;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_PLL_RST;
                end
            endcase
        end
    end

    assign pll_rst       = drives_pll_rst(state_q);
    assign vga_rst       = (state_q != ST_RUN);
    assign ready         = (state_q == ST_RUN);
    assign fault         = (state_q == ST_FAULT);
    assign state         = state_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_vga_pll_ctrl.sv
// Directed bench for vga_pll_ctrl with a phase/age reference model checked every cycle.
module tb_vga_pll_ctrl;

    localparam int HOLD    = 4;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 32;
    localparam int MAXR    = 2;

    // Debug state values as published for the block.
    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STB  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_FLT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst, vga_rst, ready, fault;
    logic [2:0] state;
    logic [7:0] lock_lost_cnt;

    vga_pll_ctrl #(
        .RST_HOLD_CYCLES     (HOLD),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAXR),
        .CNT_W               (8)
    ) dut (
        .refclk        (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .restart_req   (restart_req),
        .pll_rst       (pll_rst),
        .vga_rst       (vga_rst),
        .ready         (ready),
        .fault         (fault),
        .state         (state),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: phase, cycles spent in phase, attempts, and a two-deep
    // history of raw lock samples (the synchroniser delay).
    int m_phase = PH_RST;
    int m_age = 0;
    int m_tries = 0;
    int m_lost = 0;
    bit hist [2] = '{1'b0, 1'b0};
    bit seen;

    task automatic enter(input int ph);
        m_phase = ph;
        m_age = 0;
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            enter(PH_RST);
            m_tries = 0;
            m_lost = 0;
            hist = '{1'b0, 1'b0};
        end else begin
            seen = hist[1];
            hist[1] = hist[0];
            hist[0] = pll_locked;
            m_age++;
            if (m_phase == PH_RUN && !seen && m_lost < 255) m_lost++;
            if (restart_req) begin
                enter(PH_RST);
                m_tries = 0;
            end else begin
                case (m_phase)
                    PH_RST:  if (m_age == HOLD) enter(PH_WAIT);
                    PH_WAIT: begin
                        if (seen) enter(PH_STB);
                        else if (m_age == TIMEOUT) begin
                            if (m_tries < MAXR) begin
                                m_tries++;
                                enter(PH_RST);
                            end else enter(PH_FLT);
                        end
                    end
                    PH_STB: begin
                        if (!seen) enter(PH_WAIT);
                        else if (m_age == STABLE) enter(PH_RUN);
                    end
                    PH_RUN: begin
                        m_tries = 0;
                        if (!seen) enter(PH_RST);
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            chk("state",         int'(state),         m_phase);
            chk("pll_rst",       int'(pll_rst),       int'(m_phase == PH_RST || m_phase == PH_FLT));
            chk("vga_rst",       int'(vga_rst),       int'(m_phase != PH_RUN));
            chk("ready",         int'(ready),         int'(m_phase == PH_RUN));
            chk("fault",         int'(fault),         int'(m_phase == PH_FLT));
            chk("lock_lost_cnt", int'(lock_lost_cnt), m_lost);
        end
    end

    // Event recorder for the hand-computed timing checks.
    int   ready_rise = -1, pllrst_fall = -1, vga_rise = -1, fault_rise = -1;
    int   pllrst_falls = 0, stable_ent = 0, stable_drop = 0, rst_ent = 0;
    logic ready_p = 1'b0, pllrst_p = 1'b1, vga_p = 1'b1, fault_p = 1'b0;
    logic [2:0] state_p = 3'd0;

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            if (ready && !ready_p) ready_rise = edge_cnt;
            if (!pll_rst && pllrst_p) begin
                pllrst_fall = edge_cnt;
                pllrst_falls++;
            end
            if (vga_rst && !vga_p) vga_rise = edge_cnt;
            if (fault && !fault_p) fault_rise = edge_cnt;
            if (state == 3'd2 && state_p == 3'd1) stable_ent++;
            if (state == 3'd1 && state_p == 3'd2) stable_drop++;
            if (state == 3'd0 && state_p != 3'd0) rst_ent++;
        end
        ready_p = ready;
        pllrst_p = pll_rst;
        vga_p = vga_rst;
        fault_p = fault;
        state_p = state;
    end

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!ready && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_reset(output int e0);
        pll_locked = 1'b0;
        rst = 1'b1;
        e0 = edge_cnt;
        wait_edge(e0 + 2);
        rst = 1'b0;
    endtask

    task automatic drop_lock_once(output int a);
        a = edge_cnt + 1;
        pll_locked = 1'b0;
        wait_edge(a);
        pll_locked = 1'b1;
    endtask

    initial begin
        int a, e0, k1, f;

        // Clean bring-up: rst sampled on edges 1..3, lock first sampled at edge 10.
        wait_edge(1);
        chk("rst_state", int'(state), 0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_vga_rst", int'(vga_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_lost", int'(lock_lost_cnt), 0);
        wait_edge(3);
        rst = 1'b0;
        wait_edge(9);
        pll_locked = 1'b1;
        wait_edge(22);
        chk("bringup_pllrst_fall_edge", pllrst_fall, 7);
        chk("bringup_ready_edge", ready_rise, 20);
        chk("bringup_state", int'(state), 3);
        chk("bringup_vga_rst", int'(vga_rst), 0);

        // Single loss of lock in RUN.
        drop_lock_once(a);
        wait_edge(a + 4);
        chk("loss_vga_rise_edge", vga_rise, a + 2);
        chk("loss_ready", int'(ready), 0);
        chk("loss_cnt", int'(lock_lost_cnt), 1);
        wait_ready(60);
        wait_edge(edge_cnt + 1);
        chk("loss_rerun_edge", ready_rise, a + 15);

        // restart_req coincident with the synced lock drop.
        rst_ent = 0;
        a = edge_cnt + 1;
        pll_locked = 1'b0;
        wait_edge(a);
        pll_locked = 1'b1;
        wait_edge(a + 1);
        restart_req = 1'b1;
        wait_edge(a + 2);
        restart_req = 1'b0;
        wait_edge(a + 5);
        chk("simul_cnt", int'(lock_lost_cnt), 2);
        chk("simul_vga_rise_edge", vga_rise, a + 2);
        wait_ready(60);
        wait_edge(edge_cnt + 1);
        chk("simul_rst_entries", rst_ent, 1);
        chk("simul_rerun_edge", ready_rise, a + 15);

        // rst asserted while in STABLE.
        drop_lock_once(a);
        wait_edge(a + 9);
        chk("mid_stable_state", int'(state), 2);
        rst = 1'b1;
        wait_edge(a + 10);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_pll_rst", int'(pll_rst), 1);
        chk("mid_rst_vga_rst", int'(vga_rst), 1);
        chk("mid_rst_ready", int'(ready), 0);
        chk("mid_rst_fault", int'(fault), 0);
        chk("mid_rst_lost", int'(lock_lost_cnt), 0);
        rst = 1'b0;

        // Lock bounce: high 5, low 2, high again.
        do_reset(e0);
        stable_ent = 0;
        stable_drop = 0;
        k1 = e0 + 8;
        wait_edge(k1 - 1);
        pll_locked = 1'b1;
        wait_edge(k1 + 4);
        pll_locked = 1'b0;
        wait_edge(k1 + 6);
        pll_locked = 1'b1;
        wait_ready(60);
        wait_edge(edge_cnt + 1);
        chk("bounce_ready_edge", ready_rise, k1 + 7 + 10);
        chk("bounce_stable_entries", stable_ent, 2);
        chk("bounce_stable_drops", stable_drop, 1);

        // Timeout, retries and fault with lock held low.
        wait_edge(edge_cnt + 1);
        pllrst_falls = 0;
        do_reset(e0);
        wait_edge(e0 + 112);
        chk("timeout_fault_edge", fault_rise, e0 + 110);
        chk("timeout_pulses", pllrst_falls, 3);
        chk("fault_flag", int'(fault), 1);
        chk("fault_pll_rst", int'(pll_rst), 1);
        chk("fault_state", int'(state), 4);
        f = edge_cnt;
        restart_req = 1'b1;
        wait_edge(f + 1);
        restart_req = 1'b0;
        wait_edge(f + 2);
        chk("restart_fault", int'(fault), 0);
        chk("restart_state", int'(state), 0);
        wait_edge(f + 7);
        chk("restart_pllrst_fall_edge", pllrst_fall, f + 5);

        // Repeated loss of lock until the counter saturates.
        pll_locked = 1'b1;
        wait_ready(100);
        for (int i = 0; i < 260; i++) begin
            drop_lock_once(a);
            wait_edge(a + 3);
            if (i == 254) chk("lost_at_255", int'(lock_lost_cnt), 255);
            wait_ready(60);
        end
        wait_edge(edge_cnt + 1);
        chk("lost_saturated", int'(lock_lost_cnt), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_pll_ctrl.md
Name: vga_pll_ctrl

Overview:
- Reset/lock sequencer for the VGA pixel PLL (50 MHz ref, 25.175 MHz pixel clock plus phase-shifted copy).
- Runs in the reference-clock domain:
  - drives PLL reset with a guaranteed minimum width;
  - qualifies the asynchronous lock signal;
  - releases the VGA-domain reset only after sustained lock;
  - retries on lock timeout and restarts on loss of lock.
- Sits between board reset logic and the PLL/VGA timing block.

Parameters:
- RST_HOLD_CYCLES, 16, refclk cycles pll_rst is held high per attempt (≥1)
- LOCK_STABLE_CYCLES, 1024, consecutive synced-lock samples required before release (≥1)
- LOCK_TIMEOUT_CYCLES, 50000, max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
- MAX_RETRIES, 7, retries after the first attempt before FAULT
- CNT_W, 16, shared counter width; must hold max of the three cycle parameters

Ports:
- refclk  in  1  50 MHz reference clock; sole clock of this block
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL lock, asynchronous to refclk
- restart_req  in  1  single-cycle request to re-sequence the PLL
- pll_rst  out  1  PLL reset, active-high
- vga_rst  out  1  VGA-domain reset, active-high; released in the refclk domain, and the consumer re-syncs it to outclk
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- state  out  3  current FSM state encoding (debug)
- lock_lost_cnt  out  8  count of lock losses while in RUN; saturates at 255

Behaviour:
- Reset: the reset is synchronous, active-high, single clock (`refclk`, `rst`); it dominates every other input.
  - While `rst` is high: state=PLL_RST, counters=0, retry=0, pll_rst=1, vga_rst=1, ready=0, fault=0, lock_lost_cnt=0, sync flops=0.
- Synchroniser: pll_locked passes through a 2-flop synchroniser to give locked_s. Only locked_s is used.
- All outputs are registered and decoded from the state register.
- PLL_RST: pll_rst=1, vga_rst=1.
  - cnt increments each cycle.
  - When cnt==RST_HOLD_CYCLES-1: cnt←0, go to WAIT_LOCK.
  - Result: pll_rst is high for exactly RST_HOLD_CYCLES cycles after rst falls.
- WAIT_LOCK: pll_rst=0, vga_rst=1; cnt counts the timeout.
  - locked_s=1: cnt←0, go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT_CYCLES-1:
    - if retry<MAX_RETRIES: retry++, cnt←0, go to PLL_RST;
    - else go to FAULT.
- STABLE: pll_rst=0, vga_rst=1.
  - locked_s=0: cnt←0, go to WAIT_LOCK (timeout restarts from 0).
  - When cnt==LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN.
  - Timing: if k is the first refclk edge sampling pll_locked=1 and lock holds, vga_rst falls and ready rises at edge k+2+LOCK_STABLE_CYCLES.
- RUN: vga_rst=0, ready=1, retry←0.
  - locked_s=0: lock_lost_cnt++ (saturating), cnt←0, go to PLL_RST.
  - vga_rst reasserts on the same edge the state changes.
- FAULT: pll_rst=1, vga_rst=1, fault=1.
  - Exits only on rst or restart_req.
- restart_req: from any state, go to PLL_RST with cnt←0 and retry←0.
  - If taken in RUN on the same cycle locked_s drops: lock_lost_cnt still increments.
  - In PLL_RST it restarts the hold count, so the pulse is extended.
- Wrap/saturation: counters never wrap; each compare is an equality terminal count reset to 0. lock_lost_cnt holds at 255.
- Glitch on pll_locked shorter than 1 refclk cycle:
  - may or may not be seen (synchroniser);
  - if seen in STABLE it restarts qualification, never releases early.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

Decomposition:
- Package vga_pll_ctrl_pkg:
  - state enum/encoding constants (above);
  - default cycle parameters;
  - lock_lost_cnt width (8).
- Sub-module sync_2ff: generic 2-flop synchroniser with reset value 0; reused for other async inputs.
- FSM and counters stay in vga_pll_ctrl.

Test Plan (HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2):
- Clean bring-up: rst 3 cycles, then pll_locked rises at edge 10 and stays high.
  -> pll_rst high exactly 4 cycles after rst falls.
  -> vga_rst falls and ready rises at edge 20; state=3.
- Lock bounce: pll_locked high 5 cycles, low 2, then high.
  -> state returns STABLE→WAIT_LOCK→STABLE; vga_rst stays 1 until 8 consecutive synced highs.
- Timeout/retry/fault: pll_locked held 0.
  -> 3 pll_rst pulses of 4 cycles, each separated by 32 low cycles.
  -> then fault=1, pll_rst=1, state=4.
  -> restart_req clears fault and starts a new 4-cycle pulse.
- Loss of lock in RUN: drop pll_locked once in RUN.
  -> vga_rst=1 and ready=0 within 3 cycles; lock_lost_cnt 0→1; full re-sequence follows.
  -> repeat 260 times -> lock_lost_cnt saturates at 255.
- Simultaneous events:
  - restart_req on the same cycle locked_s drops in RUN -> single PLL_RST entry, lock_lost_cnt +1.
  - rst asserted mid-STABLE -> all outputs return to reset values next edge.
